// File: rtl/button_event_pkg.sv
// Shared front-panel definitions: button FSM encodings and default 25 MHz timing constants.
package button_event_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  localparam int DEF_DEBOUNCE_LIMIT   = 250000;    // 10 ms
  localparam int DEF_LONG_PRESS_LIMIT = 25000000;  // 1 s
  localparam int DEF_REPEAT_LIMIT     = 5000000;   // 200 ms

endpackage

// File: rtl/switch_sync_debounce.sv
// Two-flop synchroniser followed by a debounce counter producing the stable switch level.
module switch_sync_debounce
  import button_event_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = DEF_DEBOUNCE_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Stable
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);

  logic          sync_1;
  logic          sync_2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_1 <= i_Switch;
      sync_2 <= sync_1;
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_LIMIT - 1)) begin
        stable <= sync_2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign o_Stable = stable;

endmodule

// File: rtl/button_event_gen.sv
// Push-button event generator: debounced level plus press/release/long-press/repeat pulses.
// Auto-repeat is built only when BUTTON_EVENT_AUTO_REPEAT_EN is defined.
//
//   state   | meaning
//   IDLE    | button released
//   PRESSED | held, long-press time not yet reached
//   HELD    | long press reported; auto-repeat running (if built)
module button_event_gen
  import button_event_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT   = DEF_DEBOUNCE_LIMIT,
  parameter int LONG_PRESS_LIMIT = DEF_LONG_PRESS_LIMIT,
  parameter int REPEAT_LIMIT     = DEF_REPEAT_LIMIT
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Switch,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long_Press,
  output logic o_Repeat
);

  localparam int HW = $clog2(LONG_PRESS_LIMIT + 1);

  btn_state_t    state;
  btn_state_t    state_nxt;
  logic          stable;
  logic          stable_q;
  logic          press;
  logic          release_p;
  logic          long_press;
  logic          repeat_pulse;
  logic          repeat_hit;
  logic [HW-1:0] hold_cnt;

  switch_sync_debounce #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_debounce (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Switch(i_Switch),
    .o_Stable(stable)
  );

  // Edge detect against the previous stable level so pulses coincide with o_Switch changing.
  assign press     = stable & ~stable_q;
  assign release_p = ~stable & stable_q;

  always_comb begin
    state_nxt    = state;
    long_press   = 1'b0;
    repeat_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (press) state_nxt = PRESSED;
      end
      PRESSED: begin
        if (release_p) begin
          state_nxt = IDLE;
        end else if (hold_cnt == HW'(LONG_PRESS_LIMIT)) begin
          long_press = 1'b1;
          state_nxt  = HELD;
        end
      end
      HELD: begin
        if (release_p) state_nxt = IDLE;
        else           repeat_pulse = repeat_hit;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // hold_cnt counts cycles since the press cycle, so it equals LONG_PRESS_LIMIT at t+LIMIT.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state    <= IDLE;
      stable_q <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      stable_q <= stable;
      if (press) begin
        hold_cnt <= HW'(1);
      end else if (state == PRESSED && hold_cnt != HW'(LONG_PRESS_LIMIT)) begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_LIMIT + 1);

  logic [RW-1:0] rep_cnt;

  assign repeat_hit = (rep_cnt == RW'(REPEAT_LIMIT - 1));

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      rep_cnt <= '0;
    end else if (state != HELD || repeat_pulse) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + RW'(1);
    end
  end
`else
  logic repeat_unused;

  assign repeat_hit    = 1'b0;
  assign repeat_unused = (REPEAT_LIMIT != 0);
`endif

  assign o_Switch     = stable;
  assign o_Press      = press;
  assign o_Release    = release_p;
  assign o_Long_Press = long_press;
  assign o_Repeat     = repeat_pulse;

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=20, REPEAT_LIMIT=8.
module tb_button_event_gen;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic sw = 1'b0;
  logic o_sw, o_press, o_rel, o_long, o_rep;

  int vectors = 0;
  int miscompares = 0;

  int cyc, n_press, n_rel, n_long, n_rep, n_sw_high, n_overlap;
  int t_press, t_rel, t_long;
  int t_rep[8];

  button_event_gen #(
    .DEBOUNCE_LIMIT  (4),
    .LONG_PRESS_LIMIT(20),
    .REPEAT_LIMIT    (8)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_l),
    .i_Switch    (sw),
    .o_Switch    (o_sw),
    .o_Press     (o_press),
    .o_Release   (o_rel),
    .o_Long_Press(o_long),
    .o_Repeat    (o_rep)
  );

  always #5 clk = ~clk;

  task automatic clear_rec();
    cyc = 0; n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_sw_high = 0; n_overlap = 0;
    t_press = 0; t_rel = 0; t_long = 0;
    for (int i = 0; i < 8; i++) t_rep[i] = 0;
  endtask

  // Advance n clock cycles, observing outputs 1 time unit after each rising edge.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_sw) n_sw_high++;
      if (o_press) begin n_press++; if (t_press == 0) t_press = cyc; end
      if (o_rel)   begin n_rel++;   if (t_rel == 0)   t_rel = cyc;   end
      if (o_long)  begin n_long++;  if (t_long == 0)  t_long = cyc;  end
      if (o_rep)   begin if (n_rep < 8) t_rep[n_rep] = cyc; n_rep++; end
      if ((o_press && o_rel) || (o_long && o_rep)) n_overlap++;
    end
  endtask

  task automatic do_reset();
    rst_l = 1'b0; sw = 1'b0;
    run(2);
    rst_l = 1'b1;
    run(1);
  endtask

  task automatic test_reset();
    rst_l = 1'b0; sw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run(1);
      vectors++;
      if ({o_sw, o_press, o_rel, o_long, o_rep} !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 00000", i, {o_sw, o_press, o_rel, o_long, o_rep});
      end
    end
    rst_l = 1'b1;
    clear_rec();
    run(5);
    vectors++;
    if (n_press !== 0 || o_sw !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_exit_early: presses %0d switch %b expected 0 0", n_press, o_sw);
    end
    run(1);
    vectors++;
    if (o_press !== 1'b1 || o_sw !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_exit_press: press %b switch %b expected 1 1", o_press, o_sw);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    clear_rec();
    sw = 1'b1; run(3);
    sw = 1'b0; run(15);
    vectors++;
    if (n_sw_high !== 0 || n_press !== 0 || n_rel !== 0 || n_long !== 0 || n_rep !== 0) begin
      miscompares++;
      $display("FAIL glitch: sw_high %0d press %0d rel %0d long %0d rep %0d expected all 0",
               n_sw_high, n_press, n_rel, n_long, n_rep);
    end
  endtask

  task automatic test_short_press();
    do_reset();
    clear_rec();
    sw = 1'b1; run(10);
    sw = 1'b0; run(15);
    vectors++;
    if (n_press !== 1 || t_press !== 6) begin
      miscompares++;
      $display("FAIL short_press: count %0d at %0d expected 1 at 6", n_press, t_press);
    end
    vectors++;
    if (n_rel !== 1 || t_rel !== 16) begin
      miscompares++;
      $display("FAIL short_release: count %0d at %0d expected 1 at 16", n_rel, t_rel);
    end
    vectors++;
    if (n_long !== 0) begin
      miscompares++;
      $display("FAIL short_no_long: count %0d expected 0", n_long);
    end
  endtask

  task automatic test_long_press();
    int exp_rep;
    do_reset();
    clear_rec();
    sw = 1'b1; run(60);
    sw = 1'b0; run(15);
    vectors++;
    if (n_long !== 1 || t_long !== 26) begin
      miscompares++;
      $display("FAIL long_press: count %0d at %0d expected 1 at 26", n_long, t_long);
    end
    vectors++;
    if (n_rel !== 1 || t_rel !== 66) begin
      miscompares++;
      $display("FAIL long_release: count %0d at %0d expected 1 at 66", n_rel, t_rel);
    end
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    exp_rep = 4;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (t_rep[k] !== 34 + 8 * k) begin
        miscompares++;
        $display("FAIL repeat_time[%0d]: got %0d expected %0d", k, t_rep[k], 34 + 8 * k);
      end
    end
`else
    exp_rep = 0;
`endif
    vectors++;
    if (n_rep !== exp_rep) begin
      miscompares++;
      $display("FAIL repeat_count: got %0d expected %0d", n_rep, exp_rep);
    end
    vectors++;
    if (n_overlap !== 0) begin
      miscompares++;
      $display("FAIL pulse_overlap: got %0d expected 0", n_overlap);
    end
  endtask

  task automatic test_reset_in_held();
    do_reset();
    clear_rec();
    sw = 1'b1; run(30);
    vectors++;
    if (n_long !== 1) begin
      miscompares++;
      $display("FAIL held_reached: long count %0d expected 1", n_long);
    end
    clear_rec();
    rst_l = 1'b0; run(1);
    vectors++;
    if ({o_sw, o_press, o_rel, o_long, o_rep} !== 5'b0 || n_rel !== 0) begin
      miscompares++;
      $display("FAIL held_reset: outputs %b rel %0d expected 00000 0",
               {o_sw, o_press, o_rel, o_long, o_rep}, n_rel);
    end
    rst_l = 1'b1;
    clear_rec();
    run(10);
    vectors++;
    if (n_press !== 1 || t_press !== 6 || n_rel !== 0) begin
      miscompares++;
      $display("FAIL held_repress: press %0d at %0d rel %0d expected 1 at 6, 0", n_press, t_press, n_rel);
    end
    sw = 1'b0; run(10);
  endtask

  task automatic test_bounce();
    do_reset();
    clear_rec();
    for (int p = 0; p < 5; p++) begin
      sw = 1'b1; run(2);
      sw = 1'b0; run(2);
    end
    sw = 1'b1; run(10);
    vectors++;
    if (n_press !== 1 || t_press !== 26) begin
      miscompares++;
      $display("FAIL bounce_press: count %0d at %0d expected 1 at 26", n_press, t_press);
    end
    sw = 1'b0; run(10);
  endtask

  task automatic test_release_at_limit();
    do_reset();
    clear_rec();
    sw = 1'b1; run(20);
    sw = 1'b0; run(15);
    vectors++;
    if (n_rel !== 1 || t_rel !== 26 || n_long !== 0) begin
      miscompares++;
      $display("FAIL release_wins: rel %0d at %0d long %0d expected 1 at 26, 0", n_rel, t_rel, n_long);
    end
    clear_rec();
    sw = 1'b1; run(21);
    sw = 1'b0; run(15);
    vectors++;
    if (n_long !== 1 || t_long !== 26 || t_rel !== 27) begin
      miscompares++;
      $display("FAIL release_after_long: long %0d at %0d rel at %0d expected 1 at 26, 27",
               n_long, t_long, t_rel);
    end
  endtask

  initial begin
    clear_rec();
    test_reset();
    test_glitch();
    test_short_press();
    test_long_press();
    test_reset_in_held();
    test_bounce();
    test_release_at_limit();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
